// File: rtl/regfile_clr.sv
// Register file with a hardware clear sweep that zeroes every entry after reset or on request.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_clr #(
    parameter int WIDTH   = 16,
    parameter int REGBITS = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               regwrite,
    input  logic [REGBITS-1:0] wa,
    input  logic [WIDTH-1:0]   wd,
    input  logic [REGBITS-1:0] ra1,
    input  logic [REGBITS-1:0] ra2,
    output logic [WIDTH-1:0]   rd1,
    output logic [WIDTH-1:0]   rd2,
    input  logic               clr_req,
    output logic               busy,
    output logic               wr_ack
);

    localparam int DEPTH = 1 << REGBITS;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [REGBITS-1:0] ptr;
    logic               accept;
    logic [WIDTH-1:0]   ram [DEPTH];

    // A clear request outranks a simultaneous write, so accept is only raised when none is pending.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_next = CLEAR;
                end else begin
                    accept = regwrite;
                end
            end
            CLEAR: begin
                if (ptr == {REGBITS{1'b1}}) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= CLEAR;
            ptr    <= '0;
            wr_ack <= 1'b0;
        end else begin
            state  <= state_next;
            wr_ack <= accept;
            ptr    <= (state == CLEAR) ? ptr + REGBITS'(1) : '0;
        end
    end

    // Storage has no reset; zeroing is done one entry per cycle by the sweep.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            ram[ptr] <= '0;
        end else if (accept && (wa != '0)) begin
            ram[wa] <= wd;
        end
    end

    assign busy = (state == CLEAR);

    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (state == IDLE) begin
            if (ra1 != '0) begin
                rd1 = ram[ra1];
            end
            if (ra2 != '0) begin
                rd2 = ram[ra2];
            end
`ifdef REGFILE_BYPASS_EN
            if (accept && (wa != '0) && (ra1 == wa)) begin
                rd1 = wd;
            end
            if (accept && (wa != '0) && (ra2 == wa)) begin
                rd2 = wd;
            end
`endif
        end
    end

endmodule

// File: tb/tb_regfile_clr.sv
// Self-checking bench for regfile_clr: directed vector table, hand-written sweep/reset
// sequences, and randomized traffic against a cycle-level behavioural model.
module tb_regfile_clr;

    localparam int WIDTH   = 16;
    localparam int REGBITS = 4;
    localparam int DEPTH   = 16;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic               clk      = 1'b0;
    logic               reset    = 1'b0;
    logic               regwrite = 1'b0;
    logic               clr_req  = 1'b0;
    logic [REGBITS-1:0] wa       = '0;
    logic [REGBITS-1:0] ra1      = '0;
    logic [REGBITS-1:0] ra2      = '0;
    logic [WIDTH-1:0]   wd       = '0;
    logic [WIDTH-1:0]   rd1;
    logic [WIDTH-1:0]   rd2;
    logic               busy;
    logic               wr_ack;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] model_mem [DEPTH];
    int               sweep_left = 0;
    bit               model_ack  = 1'b0;

    typedef struct {
        logic             rw;
        logic [3:0]       wa;
        logic [15:0]      wd;
        logic [3:0]       ra1;
        logic [3:0]       ra2;
        logic             clr;
        logic [15:0]      e1;
        logic [15:0]      e2;
        logic             eack;
        logic             ebusy;
    } vec_t;

    vec_t vecs [8];

    regfile_clr #(.WIDTH(WIDTH), .REGBITS(REGBITS)) dut (
        .clk      (clk),
        .reset    (reset),
        .regwrite (regwrite),
        .wa       (wa),
        .wd       (wd),
        .ra1      (ra1),
        .ra2      (ra2),
        .rd1      (rd1),
        .rd2      (rd2),
        .clr_req  (clr_req),
        .busy     (busy),
        .wr_ack   (wr_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_val(input string name, input string field,
                             input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s %s: got %h expected %h", name, field, got, exp);
        end
    endtask

    task automatic check_output(input string name, input logic [15:0] e1, input logic [15:0] e2,
                                input logic eack, input logic ebusy);
        check_val(name, "rd1", rd1, e1);
        check_val(name, "rd2", rd2, e2);
        check_val(name, "wr_ack", {15'd0, wr_ack}, {15'd0, eack});
        check_val(name, "busy", {15'd0, busy}, {15'd0, ebusy});
    endtask

    // Called on a falling edge; leaves the inputs settled for the combinational reads.
    task automatic apply_stimulus(input logic rw, input logic [3:0] w_a, input logic [15:0] w_d,
                                  input logic [3:0] r1, input logic [3:0] r2, input logic clr);
        regwrite = rw;
        wa       = w_a;
        wd       = w_d;
        ra1      = r1;
        ra2      = r2;
        clr_req  = clr;
        #1;
    endtask

    function automatic bit model_accept();
        return (sweep_left == 0) && regwrite && !clr_req;
    endfunction

    function automatic logic [15:0] model_read(input logic [3:0] ra);
        if (sweep_left > 0) return 16'h0000;
        if (ra == 4'd0) return 16'h0000;
        if (BYPASS && model_accept() && (wa != 4'd0) && (ra == wa)) return wd;
        return model_mem[ra];
    endfunction

    // During a sweep reads are forced to zero and writes dropped, so zeroing
    // the whole model at sweep start is observably equivalent.
    task automatic clock_edge();
        bit acc;
        acc = model_accept();
        if (sweep_left > 0) begin
            sweep_left--;
        end else if (clr_req) begin
            sweep_left = DEPTH;
            for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        end else if (acc && (wa != 4'd0)) begin
            model_mem[wa] = wd;
        end
        model_ack = acc;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_step(input string name);
        check_output(name, model_read(ra1), model_read(ra2), model_ack, sweep_left > 0);
        clock_edge();
    endtask

    // Asserts reset away from any clock edge and checks its immediate effect.
    task automatic do_reset(input string name);
        #2;
        reset = 1'b1;
        #1;
        check_output(name, 16'h0000, 16'h0000, 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        reset      = 1'b0;
        sweep_left = DEPTH;
        model_ack  = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 4'd5, 16'hBEEF, 4'd5, 4'd5, 1'b0,
                    BYPASS ? 16'hBEEF : 16'h0000, BYPASS ? 16'hBEEF : 16'h0000, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 4'd0, 16'h0000, 4'd5, 4'd5, 1'b0, 16'hBEEF, 16'hBEEF, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 4'd0, 16'h0000, 4'd5, 4'd0, 1'b0, 16'hBEEF, 16'h0000, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 4'd0, 16'hFFFF, 4'd0, 4'd5, 1'b0, 16'h0000, 16'hBEEF, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 4'd0, 16'h0000, 4'd0, 4'd5, 1'b0, 16'h0000, 16'hBEEF, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 4'd9, 16'h5A5A, 4'd9, 4'd5, 1'b0,
                    BYPASS ? 16'h5A5A : 16'h0000, 16'hBEEF, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 4'd0, 16'h0000, 4'd9, 4'd9, 1'b0, 16'h5A5A, 16'h5A5A, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 4'd3, 16'h1234, 4'd9, 4'd5, 1'b1, 16'h5A5A, 16'hBEEF, 1'b0, 1'b0};

        @(negedge clk);
        do_reset("reset_init");

        // Sweep after reset: busy for exactly DEPTH cycles.
        for (int c = 0; c < DEPTH; c++) begin
            apply_stimulus(1'b0, 4'd0, 16'h0000, 4'(c), 4'(15 - c), 1'b0);
            check_output($sformatf("sweep%0d", c), 16'h0000, 16'h0000, 1'b0, 1'b1);
            clock_edge();
        end
        for (int c = 0; c < DEPTH; c++) begin
            apply_stimulus(1'b0, 4'd0, 16'h0000, 4'(c), 4'(c), 1'b0);
            check_output($sformatf("zero%0d", c), 16'h0000, 16'h0000, 1'b0, 1'b0);
            clock_edge();
        end

        for (int i = 0; i < 8; i++) begin
            apply_stimulus(vecs[i].rw, vecs[i].wa, vecs[i].wd, vecs[i].ra1, vecs[i].ra2, vecs[i].clr);
            check_output($sformatf("vec%0d", i), vecs[i].e1, vecs[i].e2, vecs[i].eack, vecs[i].ebusy);
            clock_edge();
        end

        // Clear won over the write: dropped writes and repeated requests during the sweep.
        for (int c = 0; c < DEPTH; c++) begin
            apply_stimulus(c == 8, 4'd7, 16'h00AA, 4'd3, 4'd7, c == 4);
            check_output($sformatf("clr%0d", c), 16'h0000, 16'h0000, 1'b0, 1'b1);
            clock_edge();
        end
        apply_stimulus(1'b0, 4'd0, 16'h0000, 4'd3, 4'd7, 1'b0);
        check_output("after_clr_a", 16'h0000, 16'h0000, 1'b0, 1'b0);
        clock_edge();
        apply_stimulus(1'b0, 4'd0, 16'h0000, 4'd5, 4'd9, 1'b0);
        check_output("after_clr_b", 16'h0000, 16'h0000, 1'b0, 1'b0);
        clock_edge();

        // Reset must clear a pending write acknowledge.
        apply_stimulus(1'b1, 4'd2, 16'h1111, 4'd2, 4'd1, 1'b0);
        model_step("pre_rst_wr");
        apply_stimulus(1'b0, 4'd0, 16'h0000, 4'd2, 4'd2, 1'b0);
        check_output("ack_before_rst", 16'h1111, 16'h1111, 1'b1, 1'b0);
        do_reset("reset_ack");
        for (int c = 0; c < DEPTH + 2; c++) begin
            apply_stimulus(1'b0, 4'd0, 16'h0000, 4'd2, 4'(c), 1'b0);
            model_step($sformatf("post_rst%0d", c));
        end

        // Reset in the middle of a sweep restarts it from the beginning.
        apply_stimulus(1'b1, 4'd6, 16'h0606, 4'd6, 4'd6, 1'b0);
        model_step("pre_mid_wr");
        apply_stimulus(1'b0, 4'd0, 16'h0000, 4'd6, 4'd6, 1'b1);
        model_step("mid_clr");
        for (int c = 0; c < 6; c++) begin
            apply_stimulus(1'b0, 4'd0, 16'h0000, 4'd6, 4'd1, 1'b0);
            model_step($sformatf("mid%0d", c));
        end
        do_reset("reset_mid");
        for (int c = 0; c < DEPTH + 2; c++) begin
            apply_stimulus(1'b0, 4'd0, 16'h0000, 4'd6, 4'(c), 1'b0);
            model_step($sformatf("restart%0d", c));
        end

        for (int n = 0; n < 400; n++) begin
            logic [3:0] w_a;
            logic [3:0] r1;
            logic [3:0] r2;
            w_a = 4'($urandom_range(0, 15));
            r1  = ($urandom_range(0, 2) == 0) ? w_a : 4'($urandom_range(0, 15));
            r2  = ($urandom_range(0, 2) == 0) ? w_a : 4'($urandom_range(0, 15));
            apply_stimulus(1'($urandom_range(0, 1)), w_a, 16'($urandom), r1, r2,
                           $urandom_range(0, 31) == 0);
            model_step($sformatf("rand%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_clr.md
REGFILE_CLR -- requirements
Module: regfile_clr

Interface
REQ-001 SHALL have parameter WIDTH, default 16: data width of every register, in bits.
REQ-002 SHALL have parameter REGBITS, default 4: address width; the file holds 2^REGBITS registers.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port regwrite, input, 1 bit: write request for the current cycle.
REQ-006 SHALL have port wa, input, REGBITS bits: write address.
REQ-007 SHALL have port wd, input, WIDTH bits: write data.
REQ-008 SHALL have ports ra1 and ra2, input, REGBITS bits each: read addresses.
REQ-009 SHALL have ports rd1 and rd2, output, WIDTH bits each: combinational read data.
REQ-010 SHALL have port clr_req, input, 1 bit: request a full-file clear sweep.
REQ-011 SHALL have port busy, output, 1 bit: high while a clear sweep runs.
REQ-012 SHALL have port wr_ack, output, 1 bit: registered one-cycle pulse confirming an accepted write.

Function
REQ-013 SHALL implement a two-state FSM, IDLE and CLEAR, with a REGBITS-bit sweep pointer ptr.
REQ-014 In CLEAR, each edge SHALL write 0 to RAM[ptr] and increment ptr; at ptr = 2^REGBITS-1 it SHALL write 0 and move to IDLE, so a sweep lasts exactly 2^REGBITS cycles.
REQ-015 SHALL drive busy = 1 exactly while the state is CLEAR.
REQ-016 In IDLE, clr_req = 1 SHALL move the FSM to CLEAR with ptr = 0 on the next edge.
REQ-017 clr_req while in CLEAR SHALL be ignored; the sweep neither restarts nor extends.
REQ-018 A write SHALL be accepted only when the state is IDLE, regwrite = 1 and clr_req = 0; RAM[wa] <= wd on that edge.
REQ-019 When clr_req and regwrite are both high in IDLE, the clear SHALL take priority, and the write SHALL be dropped without an ack.
REQ-020 Writes while busy = 1 SHALL be dropped without an ack.
REQ-021 wr_ack SHALL be 1 in the cycle after every accepted write, including writes to wa = 0, and 0 otherwise.
REQ-022 A write to wa = 0 SHALL leave register 0 unaffected; ra = 0 SHALL always read 0.
REQ-023 rd1 and rd2 SHALL read 0 while busy = 1, regardless of ra1 and ra2.
REQ-024 Otherwise rd1 SHALL equal RAM[ra1] and rd2 SHALL equal RAM[ra2], combinationally and with zero latency.
REQ-025 Both read ports SHALL be fully independent; ra1 = ra2 is legal and returns the same value on both.

Reset
REQ-026 reset = 1 SHALL asynchronously force state = CLEAR, ptr = 0 and wr_ack = 0; busy is 1 from the moment reset asserts.
REQ-027 After reset deasserts, the sweep SHALL run its full 2^REGBITS cycles, after which every register reads 0.
REQ-028 reset asserted mid-sweep SHALL restart the sweep from ptr = 0.
REQ-029 reset SHALL NOT initialise RAM contents directly; all zeroing is done by the sweep.

Configuration
REQ-030 Macro REGFILE_BYPASS_EN, when defined, SHALL forward write data to the read ports: in IDLE, with regwrite = 1, clr_req = 0, wa != 0 and ra1 = wa (or ra2 = wa), the matching rd SHALL equal wd in that same cycle.
REQ-031 When REGFILE_BYPASS_EN is undefined, the read ports SHALL return the pre-write RAM value until the edge that commits the write.
REQ-032 Bypass SHALL never apply while busy = 1 or when wa = 0.

Verification
REQ-033 Reset pulse, then wait -> busy = 1 for exactly 16 cycles after reset deasserts, then 0; reads of ra1 = 0..15 all return 0.
REQ-034 Write wa = 5, wd = 16'hBEEF, then read ra1 = 5, ra2 = 5 -> both read 16'hBEEF; wr_ack = 1 for one cycle only.
REQ-035 Write wa = 0, wd = 16'hFFFF, then read ra1 = 0 -> rd1 = 0 and wr_ack = 1.
REQ-036 Assert clr_req and regwrite together (wa = 3, wd = 16'h1234) -> no wr_ack; busy = 1 for 16 cycles; then ra1 = 3 reads 0.
REQ-037 Attempt a write (wa = 7, wd = 16'h00AA) at sweep cycle 8 -> no wr_ack; after the sweep, ra2 = 7 reads 0.
REQ-038 In the same cycle as a write wa = 9, wd = 16'h5A5A, set ra1 = 9 -> rd1 = 16'h5A5A with REGFILE_BYPASS_EN defined, and the old value without it.
